data_memory: RTL and testbench

// - Word-addressed data memory: the responder on the core's data-memory port (read/write/address/data_out in, data_in back).
// - Sits beside the core in the top level and in testbench; replaces hand-driven data_in stimulus.
// - Optional wait-state sequencer to model slow memory; ready output for the core's future stall logic.
//

---
 rtl/data_memory.sv | 193 +++++++++++++++++++
 tb/tb_data_memory.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed data memory responding to the core's data port, with an optional
// wait-state sequencer. Define DATA_MEMORY_BOUNDS_CHECK_EN to add the sticky error port.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module data_memory #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic                     write,
    input  logic [`ADDRESS_SIZE-1:0] address,
    input  logic [`DATA_SIZE-1:0]    data_out,
    output logic [`DATA_SIZE-1:0]    data_in,
    output logic                     ready
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    ,
    output logic                     error
`endif
);

    localparam int unsigned ADDR_W   = `ADDRESS_SIZE;
    localparam int unsigned DATA_W   = `DATA_SIZE;
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = 4;
    localparam bit          HAS_WAIT = (WAIT_STATES != 0);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    localparam bit          BOUNDS_EN = 1'b1;
`else
    localparam bit          BOUNDS_EN = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lat_wr_q, lat_wr_d;
    logic               lat_rd_q, lat_rd_d;
    logic               lat_oob_q, lat_oob_d;
    logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;
    logic [DATA_W-1:0]  lat_data_q, lat_data_d;
    logic               ready_d;
    logic [DATA_W-1:0]  data_in_d;

    // Access being performed at the coming edge (direct or from latched request)
    logic               acc_go;
    logic               acc_wr;
    logic               acc_rd;
    logic               acc_oob;
    logic [IDX_W-1:0]   acc_idx;
    logic [DATA_W-1:0]  acc_data;
    logic               mem_we;

    logic               req;
    logic               in_oob;
    logic [IDX_W-1:0]   in_idx;

    assign req    = read | write;
    assign in_idx = address[IDX_W-1:0];
    assign in_oob = (address >> IDX_W) != ADDR_W'(0);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req && HAS_WAIT) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic: request latching, countdown and access selection
    always_comb begin
        cnt_d      = cnt_q;
        lat_wr_d   = lat_wr_q;
        lat_rd_d   = lat_rd_q;
        lat_oob_d  = lat_oob_q;
        lat_idx_d  = lat_idx_q;
        lat_data_d = lat_data_q;
        ready_d    = ready;
        acc_go     = 1'b0;
        acc_wr     = lat_wr_q;
        acc_rd     = lat_rd_q;
        acc_oob    = lat_oob_q;
        acc_idx    = lat_idx_q;
        acc_data   = lat_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (HAS_WAIT) begin
                        lat_wr_d   = write;
                        lat_rd_d   = read & ~write;
                        lat_oob_d  = in_oob;
                        lat_idx_d  = in_idx;
                        lat_data_d = data_out;
                        cnt_d      = CNT_W'(WAIT_STATES);
                        ready_d    = 1'b0;
                    end else begin
                        acc_go   = 1'b1;
                        acc_wr   = write;
                        acc_rd   = read & ~write;
                        acc_oob  = in_oob;
                        acc_idx  = in_idx;
                        acc_data = data_out;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    acc_go  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            default: begin
                cnt_d   = CNT_W'(0);
                ready_d = 1'b1;
            end
        endcase
    end

    // Out-of-range accesses are squashed only when bounds checking is built in
    assign mem_we = acc_go & acc_wr & ~(BOUNDS_EN & acc_oob);

    always_comb begin
        data_in_d = data_in;
        if (acc_go && acc_rd) begin
            data_in_d = (BOUNDS_EN && acc_oob) ? DATA_W'(0) : mem[acc_idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= CNT_W'(0);
            lat_wr_q   <= 1'b0;
            lat_rd_q   <= 1'b0;
            lat_oob_q  <= 1'b0;
            lat_idx_q  <= IDX_W'(0);
            lat_data_q <= DATA_W'(0);
            data_in    <= DATA_W'(0);
            ready      <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            lat_wr_q   <= lat_wr_d;
            lat_rd_q   <= lat_rd_d;
            lat_oob_q  <= lat_oob_d;
            lat_idx_q  <= lat_idx_d;
            lat_data_q <= lat_data_d;
            data_in    <= data_in_d;
            ready      <= ready_d;
        end
    end

    // Storage array is intentionally not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_data;
        end
    end

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    // Sticky fault on accepted out-of-range or read+write requests
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            error <= 1'b0;
        end else if (state_q == ST_IDLE && req && (in_oob || (read && write))) begin
            error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a single-cycle instance and a 3-wait-state instance
// checked against a reference array model.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif

module tb_data_memory;

    localparam int AW = `ADDRESS_SIZE;
    localparam int DW = `DATA_SIZE;
    localparam int WS3 = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;

    logic          rd0 = 1'b0, wr0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] wd0 = '0;
    logic [DW-1:0] q0;
    logic          rdy0;
    logic          err0;

    logic          rd3 = 1'b0, wr3 = 1'b0;
    logic [AW-1:0] addr3 = '0;
    logic [DW-1:0] wd3 = '0;
    logic [DW-1:0] q3;
    logic          rdy3;
    logic          err3;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mdl0 [256];
    logic [DW-1:0] mdl3 [256];
    logic [DW-1:0] last0 = '0, last3 = '0;
    logic          eerr0 = 1'b0, eerr3 = 1'b0;
    logic [DW-1:0] sb0 [$];
    logic [DW-1:0] sb3 [$];

    always #5 clock = ~clock;

    data_memory #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset(reset), .read(rd0), .write(wr0), .address(addr0),
        .data_out(wd0), .data_in(q0), .ready(rdy0)
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        , .error(err0)
`endif
    );

    data_memory #(.DEPTH(256), .WAIT_STATES(WS3)) u_dut3 (
        .clock(clock), .reset(reset), .read(rd3), .write(wr3), .address(addr3),
        .data_out(wd3), .data_in(q3), .ready(rdy3)
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        , .error(err3)
`endif
    );

`ifndef DATA_MEMORY_BOUNDS_CHECK_EN
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    // Reference behaviour of one accepted request; returns expected data_in afterwards
    function automatic void model(input logic rd, input logic wr, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d, inout logic [DW-1:0] m [256],
                                  inout logic [DW-1:0] last, inout logic eerr);
        logic [7:0] idx;
        logic       oob;
        idx = a[7:0];
        oob = (a >> 8) != 0;
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        if ((rd || wr) && (oob || (rd && wr))) eerr = 1'b1;
        if (wr && !oob) m[idx] = d;
        else if (rd && !wr) last = oob ? '0 : m[idx];
`else
        if (wr) m[idx] = d;
        else if (rd) last = m[idx];
`endif
    endfunction

    task automatic op0(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input string name);
        logic [DW-1:0] exp;
        rd0 = rd; wr0 = wr; addr0 = a; wd0 = d;
        model(rd, wr, a, d, mdl0, last0, eerr0);
        sb0.push_back(last0);
        @(posedge clock);
        @(negedge clock);
        rd0 = 1'b0; wr0 = 1'b0;
        exp = sb0.pop_front();
        checks++;
        if (q0 !== exp) begin
            errors++;
            $display("FAIL %s data_in: got %h expected %h", name, q0, exp);
        end
        checks++;
        if (rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL %s ready0: got %b expected 1", name, rdy0);
        end
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        checks++;
        if (err0 !== eerr0) begin
            errors++;
            $display("FAIL %s error0: got %b expected %b", name, err0, eerr0);
        end
`endif
    endtask

    task automatic op3(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input string name);
        logic [DW-1:0] exp;
        int low;
        bit done;
        rd3 = rd; wr3 = wr; addr3 = a; wd3 = d;
        model(rd, wr, a, d, mdl3, last3, eerr3);
        sb3.push_back(last3);
        @(posedge clock);
        @(negedge clock);
        // Scramble inputs while busy; they must be ignored
        rd3 = 1'b1; wr3 = 1'b1; addr3 = a ^ AW'(1); wd3 = ~d;
        low = 0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rdy3 === 1'b1) begin
                done = 1'b1;
                break;
            end
            low++;
            @(negedge clock);
        end
        rd3 = 1'b0; wr3 = 1'b0;
        checks++;
        if (!done || low != WS3) begin
            errors++;
            $display("FAIL %s ready_low_cycles: got %0d expected %0d", name, low, WS3);
        end
        exp = sb3.pop_front();
        checks++;
        if (q3 !== exp) begin
            errors++;
            $display("FAIL %s data_in3: got %h expected %h", name, q3, exp);
        end
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        checks++;
        if (err3 !== eerr3) begin
            errors++;
            $display("FAIL %s error3: got %b expected %b", name, err3, eerr3);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (q0 !== '0 || rdy0 !== 1'b1 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL reset0: data_in=%h ready=%b error=%b expected 0/1/0", q0, rdy0, err0);
        end
        checks++;
        if (q3 !== '0 || rdy3 !== 1'b1 || err3 !== 1'b0) begin
            errors++;
            $display("FAIL reset3: data_in=%h ready=%b error=%b expected 0/1/0", q3, rdy3, err3);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_cycle();
        op0(1'b0, 1'b1, AW'('h5), 32'hDEADBEEF, "wr5");
        op0(1'b1, 1'b0, AW'('h5), '0, "rd5");
        for (int i = 0; i < 4; i++) op0(1'b0, 1'b1, AW'('h40 + i), DW'($urandom), "wr_burst");
        op0(1'b0, 1'b1, AW'('h41), 32'h5A5A_0001, "wr_hold");
        for (int i = 3; i >= 0; i--) op0(1'b1, 1'b0, AW'('h40 + i), '0, "rd_burst");
        op0(1'b0, 1'b1, AW'('h42), 32'h1234_5678, "wr_then_rd");
        op0(1'b1, 1'b0, AW'('h42), '0, "rd_after_wr");
        op0(1'b0, 1'b1, AW'('hFF), 32'hFFFF_0000, "wr_top");
        op0(1'b1, 1'b0, AW'('hFF), '0, "rd_top");
    endtask

    task automatic test_read_write_both();
        op0(1'b0, 1'b1, AW'('h2), 32'h11, "wr2_init");
        op0(1'b1, 1'b0, AW'('h5), '0, "rd5_prime");
        op0(1'b1, 1'b1, AW'('h2), 32'h0D, "rw_both");
        op0(1'b1, 1'b0, AW'('h2), '0, "rd2_after_both");
    endtask

    task automatic test_wrap();
        op0(1'b0, 1'b1, AW'('hAB), 32'h77, "wr_ab");
        op0(1'b0, 1'b1, AW'('h1AB), 32'hE, "wr_1ab");
        op0(1'b1, 1'b0, AW'('hAB), '0, "rd_ab");
        op0(1'b1, 1'b0, AW'('h1AB), '0, "rd_1ab");
    endtask

    task automatic test_wait_states();
        op3(1'b0, 1'b1, AW'('h10), 32'h0000_000A, "w3_preload");
        op3(1'b1, 1'b0, AW'('h10), '0, "w3_rd10");
        op3(1'b0, 1'b1, AW'('h11), 32'hCAFE_F00D, "w3_wr11");
        op3(1'b1, 1'b0, AW'('h11), '0, "w3_rd11");
        op3(1'b1, 1'b0, AW'('h10), '0, "w3_rd10_again");
    endtask

    task automatic test_reset_mid_access();
        op3(1'b0, 1'b1, AW'('h3), 32'h33, "w3_wr3_old");
        rd3 = 1'b0; wr3 = 1'b1; addr3 = AW'('h3); wd3 = 32'h99;
        @(posedge clock);
        @(negedge clock);
        wr3 = 1'b0;
        checks++;
        if (rdy3 !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: ready=%b expected 0", rdy3);
        end
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        last0 = '0; last3 = '0; eerr0 = 1'b0; eerr3 = 1'b0;
        checks++;
        if (rdy3 !== 1'b1 || q3 !== '0 || q0 !== '0) begin
            errors++;
            $display("FAIL mid_reset: ready3=%b data_in3=%h data_in0=%h expected 1/0/0", rdy3, q3, q0);
        end
        reset = 1'b1;
        @(negedge clock);
        op3(1'b1, 1'b0, AW'('h3), '0, "w3_rd3_old");
        op0(1'b1, 1'b0, AW'('h5), '0, "rd5_after_reset");
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_read_write_both();
        test_wrap();
        test_wait_states();
        test_reset_mid_access();
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
